// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller: FSM state encoding, the
// timeout limit, the error read pattern, and the latched request record.
// Imported by mem_ctrl and mem_timeout.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Number of ACCESS cycles allowed without bus_ack before aborting.
    localparam logic [7:0]  MEM_TIMEOUT  = 8'd255;

    // Read data returned when a read is aborted by the timeout.
    localparam logic [15:0] MEM_ERR_DATA = 16'hFFFF;

    // Request captured at accept time and replayed onto the bus.
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    // Two-way source select used for both address and write-data muxing.
    function automatic logic [15:0] src_sel(input logic        sel,
                                            input logic [15:0] when_one,
                                            input logic [15:0] when_zero);
        return sel ? when_one : when_zero;
    endfunction

endpackage

// File: rtl/mem_timeout.sv
// Access watchdog: counts ACCESS cycles since the last accept and flags the
// cycle in which the MEM_TIMEOUT-th ACCESS cycle is reached.
// Ports: clk, rst (sync, active-high), clear (accept), enable (in ACCESS),
// expired (combinational, high only while enable is high).
module mem_timeout
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] r_count;

    // r_count holds the number of ACCESS cycles already completed, so the
    // MEM_TIMEOUT-th ACCESS cycle sees r_count == MEM_TIMEOUT-1.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= 8'd0;
        end else if (enable && !expired) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expired = enable && (r_count == (MEM_TIMEOUT - 8'd1));

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding memory access controller between the instruction decoder
// and a req/ack bus. Reads complete with a one-cycle mem_ready pulse; writes
// are posted. Ports: decoder requests and address/data sources in, mem_busy /
// mem_ready / rdata out, bus_req/we/addr/wdata out, bus_rdata/bus_ack in.
// Optional MEM_CTRL_TIMEOUT_EN adds an ACCESS watchdog and a sticky bus_err.
module mem_ctrl
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic        mem_sp,
    input  logic        mdata_sp,
    input  logic [15:0] alu_out,
    input  logic [15:0] sp,
    input  logic [15:0] pc,
    input  logic [15:0] reg_r_data,
    output logic        mem_busy,
    output logic        mem_ready,
    output logic [15:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
`ifdef MEM_CTRL_TIMEOUT_EN
    output logic        bus_err,
`endif
    input  logic        bus_ack
);

    state_t      r_state;
    state_t      w_state_nxt;
    req_t        r_req;
    req_t        w_req_in;
    logic [15:0] r_rdata;
    logic        w_accept;
    logic        w_timeout;
    logic        w_abort;

    // Write wins when both requests arrive together; the read is dropped.
    assign w_req_in.we    = ram_write;
    assign w_req_in.addr  = src_sel(mem_sp,   sp, alu_out);
    assign w_req_in.wdata = src_sel(mdata_sp, pc, reg_r_data);

`ifdef MEM_CTRL_TIMEOUT_EN
    logic r_bus_err;

    mem_timeout u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_accept),
        .enable  (r_state == ACCESS),
        .expired (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_err <= 1'b0;
        end else if (w_abort) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
`endif

    // An ack in the expiring cycle still completes the access normally.
    assign w_abort = w_timeout && !bus_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs decode only registered state and latches, so they never
    // follow decoder or bus inputs combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        mem_busy    = 1'b0;
        mem_ready   = 1'b0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = 16'h0000;
        bus_wdata   = 16'h0000;
        case (r_state)
            IDLE: begin
                if (ram_read || ram_write) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_busy  = 1'b1;
                bus_req   = 1'b1;
                bus_we    = r_req.we;
                bus_addr  = r_req.addr;
                bus_wdata = r_req.wdata;
                if (bus_ack || w_abort) begin
                    w_state_nxt = r_req.we ? IDLE : DONE;
                end
            end
            DONE: begin
                mem_ready   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req   <= '0;
            r_rdata <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_req <= w_req_in;
            end
            if ((r_state == ACCESS) && !r_req.we) begin
                if (bus_ack) begin
                    r_rdata <= bus_rdata;
                end else if (w_abort) begin
                    r_rdata <= MEM_ERR_DATA;
                end
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_read;
    logic        ram_write;
    logic        mem_sp;
    logic        mdata_sp;
    logic [15:0] alu_out;
    logic [15:0] sp;
    logic [15:0] pc;
    logic [15:0] reg_r_data;
    logic        mem_busy;
    logic        mem_ready;
    logic [15:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
`ifdef MEM_CTRL_TIMEOUT_EN
    logic        bus_err;
`endif

    int errors = 0;
    int checks = 0;

    // Reference state: last completed read value.
    logic [15:0] exp_rdata;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .mem_sp     (mem_sp),
        .mdata_sp   (mdata_sp),
        .alu_out    (alu_out),
        .sp         (sp),
        .pc         (pc),
        .reg_r_data (reg_r_data),
        .mem_busy   (mem_busy),
        .mem_ready  (mem_ready),
        .rdata      (rdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
`ifdef MEM_CTRL_TIMEOUT_EN
        .bus_err    (bus_err),
`endif
        .bus_ack    (bus_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  {31'd0, mem_busy},  32'd0);
        chk({tag, "_ready"}, {31'd0, mem_ready}, 32'd0);
        chk({tag, "_req"},   {31'd0, bus_req},   32'd0);
        chk({tag, "_we"},    {31'd0, bus_we},    32'd0);
        chk({tag, "_addr"},  {16'd0, bus_addr},  32'd0);
        chk({tag, "_wdata"}, {16'd0, bus_wdata}, 32'd0);
    endtask

    // Called right after a negedge with the DUT idle. Issues one request in
    // that cycle (N); cycle c is N+c. Expected behaviour: ACCESS for cycles
    // 1..waits+1 with ack in the last of them, read DONE at waits+2, idle
    // afterwards. With junk set, new requests and source changes are driven
    // while the controller is busy and must have no effect.
    task automatic run_txn(input logic rd, input logic wr,
                           input logic msp, input logic mdsp,
                           input logic [15:0] a_alu, input logic [15:0] a_sp,
                           input logic [15:0] a_pc,  input logic [15:0] a_reg,
                           input int waits, input logic [15:0] rdat,
                           input logic junk);
        logic        e_we;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_busy;
        logic        e_rdy;
        e_we    = wr;
        e_addr  = msp  ? a_sp : a_alu;
        e_wdata = mdsp ? a_pc : a_reg;
        ram_read   = rd;
        ram_write  = wr;
        mem_sp     = msp;
        mdata_sp   = mdsp;
        alu_out    = a_alu;
        sp         = a_sp;
        pc         = a_pc;
        reg_r_data = a_reg;
        bus_ack    = 1'b0;
        bus_rdata  = 16'($urandom);
        for (int c = 1; c <= waits + 3; c++) begin
            @(negedge clk);
            if (!e_we && c == waits + 2) exp_rdata = rdat;
            e_busy = (c <= waits + 1);
            e_rdy  = !e_we && (c == waits + 2);
            chk("busy",  {31'd0, mem_busy},  {31'd0, e_busy});
            chk("ready", {31'd0, mem_ready}, {31'd0, e_rdy});
            chk("req",   {31'd0, bus_req},   {31'd0, e_busy});
            chk("we",    {31'd0, bus_we},    {31'd0, e_busy & e_we});
            chk("addr",  {16'd0, bus_addr},  {16'd0, e_busy ? e_addr  : 16'h0000});
            chk("wdata", {16'd0, bus_wdata}, {16'd0, e_busy ? e_wdata : 16'h0000});
            chk("rdata", {16'd0, rdata},     {16'd0, exp_rdata});
            if (junk && (c <= waits + 1 || (!e_we && c == waits + 2))) begin
                ram_read   = 1'($urandom);
                ram_write  = 1'($urandom);
                mem_sp     = 1'($urandom);
                mdata_sp   = 1'($urandom);
                alu_out    = 16'($urandom);
                sp         = 16'($urandom);
                pc         = 16'($urandom);
                reg_r_data = 16'($urandom);
            end else begin
                ram_read  = 1'b0;
                ram_write = 1'b0;
            end
            if (c == waits + 1) begin
                bus_ack   = 1'b1;
                bus_rdata = rdat;
            end else if (c > waits + 1 && c < waits + 3) begin
                bus_ack   = 1'($urandom);
                bus_rdata = 16'($urandom);
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = 16'($urandom);
            end
        end
        ram_read  = 1'b0;
        ram_write = 1'b0;
        bus_ack   = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int ready_at;
        logic rd;
        logic wr;
        rst        = 1'b1;
        ram_read   = 1'b0;
        ram_write  = 1'b0;
        mem_sp     = 1'b0;
        mdata_sp   = 1'b0;
        alu_out    = 16'h0;
        sp         = 16'h0;
        pc         = 16'h0;
        reg_r_data = 16'h0;
        bus_rdata  = 16'h0;
        bus_ack    = 1'b0;
        exp_rdata  = 16'h0000;

        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_rdata", {16'd0, rdata}, 32'd0);
`ifdef MEM_CTRL_TIMEOUT_EN
        chk("reset_err", {31'd0, bus_err}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Read from alu_out, ack in the third ACCESS cycle.
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h1111, 16'h2222, 16'h3333,
                2, 16'hBEEF, 1'b0);
        chk("read_rdata", {16'd0, rdata}, 32'h0000BEEF);

        // Posted write from sp/pc, immediate ack.
        run_txn(1'b0, 1'b1, 1'b1, 1'b1, 16'h5555, 16'hFFFE, 16'h0123, 16'h7777,
                0, 16'hDEAD, 1'b0);
        chk("write_keeps_rdata", {16'd0, rdata}, 32'h0000BEEF);

        // Both requests together: write only; requests while busy ignored.
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D,
                3, 16'h1234, 1'b1);

        // Back-to-back zero-wait reads.
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0, 16'h0, 16'h0,
                0, 16'h0001, 1'b0);
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0200, 16'h0, 16'h0,
                0, 16'h0002, 1'b0);
        chk("b2b_rdata", {16'd0, rdata}, 32'h00000002);

        // Randomised transactions with junk requests while busy.
        for (int t = 0; t < 40; t++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            run_txn(rd, wr, 1'($urandom), 1'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 5)), 16'($urandom), 1'($urandom));
        end

        // Reset in the second ACCESS cycle of a read aborts it.
        ram_read = 1'b1;
        alu_out  = 16'h0777;
        mem_sp   = 1'b0;
        @(negedge clk);
        ram_read = 1'b0;
        chk("abort_c1_busy", {31'd0, mem_busy}, 32'd1);
        @(negedge clk);
        chk("abort_c2_busy", {31'd0, mem_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        exp_rdata = 16'h0000;
        chk_idle_outputs("abort");
        bus_ack   = 1'b1;
        bus_rdata = 16'hCAFE;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_idle_outputs("late_ack");
            chk("late_ack_rdata", {16'd0, rdata}, {16'd0, exp_rdata});
        end
        bus_ack = 1'b0;

`ifdef MEM_CTRL_TIMEOUT_EN
        chk("err_clear_after_rst", {31'd0, bus_err}, 32'd0);
        // Read that is never acknowledged.
        ram_read = 1'b1;
        alu_out  = 16'h0999;
        busy_cnt = 0;
        ready_at = 0;
        for (int c = 1; c <= 300 && ready_at == 0; c++) begin
            @(negedge clk);
            ram_read = 1'b0;
            if (mem_busy) busy_cnt++;
            if (mem_ready) ready_at = c;
        end
        chk("to_busy_cycles", busy_cnt, 32'd255);
        chk("to_ready_cycle", ready_at, 32'd256);
        chk("to_rdata", {16'd0, rdata}, 32'h0000FFFF);
        chk("to_err", {31'd0, bus_err}, 32'd1);
        exp_rdata = 16'hFFFF;
        @(negedge clk);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0, 16'h0, 16'h0,
                1, 16'h4242, 1'b0);
        chk("err_sticky", {31'd0, bus_err}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_reset", {31'd0, bus_err}, 32'd0);
`else
        busy_cnt = 0;
        ready_at = 0;
        chk("no_to_idle", {31'd0, mem_busy}, {31'd0, 1'(busy_cnt + ready_at)});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
